// File: rtl/key_debounce_fsm_if.sv
// Key debouncer signal bundle: raw key and 1 kHz tick in, debounced level/events out.
// slave = the debouncer, master = whoever drives the key and the tick.
interface key_debounce_fsm_if;
    logic       tick_clk;
    logic       key_in;
    logic       key_state;
    logic       key_flag;
    logic       key_rel;
    logic [7:0] press_cnt;
    logic       key_long;

    modport master (
        output tick_clk, key_in,
        input  key_state, key_flag, key_rel, press_cnt, key_long
    );

    modport slave (
        input  tick_clk, key_in,
        output key_state, key_flag, key_rel, press_cnt, key_long
    );
endinterface

// File: rtl/key_debounce_fsm.sv
// Active-low key debouncer sampled on a synchronised 1 kHz tick; four-state filter FSM.
// Optional long-press pulse enabled by defining KEY_LONG_PRESS_EN.
module key_debounce_fsm #(
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    key_debounce_fsm_if.slave kif
);

    if (DEBOUNCE_MS < 1 || DEBOUNCE_MS > 255 || LONG_MS < 1 || LONG_MS > 65535) begin : g_param_range
        $error("key_debounce_fsm: DEBOUNCE_MS or LONG_MS out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_FILT,
        DOWN,
        RELEASE_FILT
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_MS - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       key_meta;
    logic       key_s;
    logic       tick_meta;
    logic       tick_s;
    logic       tick_prev;
    logic       tick;
    logic       state_q;
    logic       flag_q;
    logic       rel_q;
    logic [7:0] press_q;

    // tick_clk is data here: synchronise, then register its rising edge as a one-cycle tick.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_meta  <= 1'b1;
            key_s     <= 1'b1;
            tick_meta <= 1'b0;
            tick_s    <= 1'b0;
            tick_prev <= 1'b0;
            tick      <= 1'b0;
        end else begin
            key_meta  <= kif.key_in;
            key_s     <= key_meta;
            tick_meta <= kif.tick_clk;
            tick_s    <= tick_meta;
            tick_prev <= tick_s;
            tick      <= tick_s & ~tick_prev;
        end
    end

`ifdef KEY_LONG_PRESS_EN
    localparam logic [15:0] LONG_LAST = 16'(LONG_MS - 1);

    logic [15:0] hold_cnt;
    logic        long_armed;
    logic        long_q;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            state_q <= 1'b0;
            flag_q  <= 1'b0;
            rel_q   <= 1'b0;
            press_q <= '0;
`ifdef KEY_LONG_PRESS_EN
            hold_cnt   <= '0;
            long_armed <= 1'b0;
            long_q     <= 1'b0;
`endif
        end else begin
            flag_q <= 1'b0;
            rel_q  <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
            long_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!key_s) begin
                        state <= PRESS_FILT;
                        cnt   <= '0;
                    end
                end
                PRESS_FILT: begin
                    // A bounce outranks a coincident tick: clear, never count.
                    if (key_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (cnt == CNT_LAST) begin
                            state   <= DOWN;
                            cnt     <= '0;
                            state_q <= 1'b1;
                            flag_q  <= 1'b1;
                            press_q <= press_q + 8'd1;
`ifdef KEY_LONG_PRESS_EN
                            hold_cnt   <= '0;
                            long_armed <= 1'b1;
`endif
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                DOWN: begin
                    if (key_s) begin
                        state <= RELEASE_FILT;
                        cnt   <= '0;
                    end
`ifdef KEY_LONG_PRESS_EN
                    // Hold count survives release glitches; only a fresh press re-arms it.
                    else if (tick && long_armed) begin
                        hold_cnt <= hold_cnt + 16'd1;
                        if (hold_cnt == LONG_LAST) begin
                            long_q     <= 1'b1;
                            long_armed <= 1'b0;
                        end
                    end
`endif
                end
                RELEASE_FILT: begin
                    if (!key_s) begin
                        state <= DOWN;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (cnt == CNT_LAST) begin
                            state   <= IDLE;
                            cnt     <= '0;
                            state_q <= 1'b0;
                            rel_q   <= 1'b1;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign kif.key_state = state_q;
    assign kif.key_flag  = flag_q;
    assign kif.key_rel   = rel_q;
    assign kif.press_cnt = press_q;
`ifdef KEY_LONG_PRESS_EN
    assign kif.key_long  = long_q;
`else
    assign kif.key_long  = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce_fsm.sv
// Scoreboard bench for key_debounce_fsm: expected key events (kind, tick index, count)
// are queued as the key is driven and matched when the DUT pulses an output.
module tb_key_debounce_fsm;

    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 10;
    localparam int K_FLAG = 0;
    localparam int K_REL  = 1;
    localparam int K_LONG = 2;
    localparam int K_NONE = 3;

    typedef struct {
        int          kind;
        int unsigned tick;
        int unsigned cnt;
    } ev_t;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    int unsigned n_checks  = 0;
    int unsigned n_fail    = 0;
    int unsigned tick_edges = 0;
    int unsigned exp_cnt   = 0;
    ev_t         sb[$];

    key_debounce_fsm_if kif ();

    key_debounce_fsm #(
        .DEBOUNCE_MS (DEB),
        .LONG_MS     (LONG)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .kif       (kif)
    );

    always #5 sys_clk = ~sys_clk;

    initial kif.tick_clk = 1'b0;
    always #100 kif.tick_clk = ~kif.tick_clk;
    always @(posedge kif.tick_clk) tick_edges++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int kind, input int unsigned tick, input int unsigned cnt);
        ev_t e;
        e.kind = kind;
        e.tick = tick;
        e.cnt  = cnt;
        sb.push_back(e);
    endtask

    task automatic wait_ticks(input int unsigned n);
        repeat (n) @(negedge kif.tick_clk);
    endtask

    // Key edges land on tick_clk falling edges, half a tick period from the next sample.
    task automatic press_release(input int unsigned hold, input int unsigned gap);
        int unsigned k;
        @(negedge kif.tick_clk);
        k = tick_edges;
        kif.key_in = 1'b0;
        exp_cnt = (exp_cnt + 1) % 256;
        push(K_FLAG, k + DEB, exp_cnt);
`ifdef KEY_LONG_PRESS_EN
        if (hold >= DEB + LONG) push(K_LONG, k + DEB + LONG, 0);
`endif
        wait_ticks(hold);
        kif.key_in = 1'b1;
        push(K_REL, tick_edges + DEB, 0);
        wait_ticks(gap);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 4000 && sb.size() != 0; i++) @(negedge sys_clk);
        check(tag, sb.size(), 0);
        sb.delete();
    endtask

    always @(negedge sys_clk) begin : monitor
        ev_t e;
        int  kind;
        if (sys_rst_n && (kif.key_flag || kif.key_rel || kif.key_long)) begin
            if (kif.key_flag && kif.key_rel) check("flag_rel_excl", 1, 0);
            kind = kif.key_flag ? K_FLAG : (kif.key_rel ? K_REL : K_LONG);
            if (sb.size() == 0) begin
                check("unexpected_evt", kind, K_NONE);
            end else begin
                e = sb.pop_front();
                check("evt_kind", kind, e.kind);
                check("evt_tick", tick_edges, e.tick);
                if (kind == K_FLAG) begin
                    check("flag_cnt", kif.press_cnt, e.cnt);
                    check("flag_state", kif.key_state, 1);
                end else if (kind == K_REL) begin
                    check("rel_state", kif.key_state, 0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int unsigned k;
        kif.key_in = 1'b0;
        sys_rst_n  = 1'b0;
        repeat (18) begin
            @(negedge sys_clk);
            kif.key_in = ~kif.key_in;
        end
        check("rst_state", kif.key_state, 0);
        check("rst_flag",  kif.key_flag, 0);
        check("rst_rel",   kif.key_rel, 0);
        check("rst_cnt",   kif.press_cnt, 0);
        check("rst_long",  kif.key_long, 0);
        kif.key_in = 1'b1;
        @(negedge kif.tick_clk);
        sys_rst_n = 1'b1;
        wait_ticks(3);
        check("post_rst_state", kif.key_state, 0);
        check("post_rst_cnt",   kif.press_cnt, 0);

        // clean press held 8 ticks
        press_release(8, 6);
        drain("clean_drain");
        check("clean_cnt", kif.press_cnt, 1);

        // bounce: 2 low, 1 high, then 6 low
        @(negedge kif.tick_clk);
        kif.key_in = 1'b0;
        wait_ticks(2);
        kif.key_in = 1'b1;
        wait_ticks(1);
        k = tick_edges;
        kif.key_in = 1'b0;
        exp_cnt++;
        push(K_FLAG, k + DEB, exp_cnt);
        wait_ticks(6);
        kif.key_in = 1'b1;
        push(K_REL, tick_edges + DEB, 0);
        wait_ticks(6);
        drain("bounce_drain");

        // 2-tick glitch only
        @(negedge kif.tick_clk);
        kif.key_in = 1'b0;
        wait_ticks(2);
        kif.key_in = 1'b1;
        wait_ticks(6);
        check("glitch_cnt", kif.press_cnt, exp_cnt);
        check("glitch_state", kif.key_state, 0);

        // release glitch of one tick
        @(negedge kif.tick_clk);
        k = tick_edges;
        kif.key_in = 1'b0;
        exp_cnt++;
        push(K_FLAG, k + DEB, exp_cnt);
        wait_ticks(6);
        kif.key_in = 1'b1;
        wait_ticks(1);
        kif.key_in = 1'b0;
        wait_ticks(2);
        check("relglitch_state", kif.key_state, 1);
        kif.key_in = 1'b1;
        push(K_REL, tick_edges + DEB, 0);
        wait_ticks(6);
        drain("relglitch_drain");

        // long press: 15 ticks fires (with feature), 9 ticks does not
        press_release(15, 6);
        press_release(9, 6);
        drain("long_drain");
        check("long_quiet", kif.key_long, 0);

        // wrap press_cnt back to 0
        do press_release(5, 5); while (exp_cnt != 0);
        drain("wrap_drain");
        check("wrap_cnt", kif.press_cnt, 0);

        // reset while DOWN with key still held
        @(negedge kif.tick_clk);
        kif.key_in = 1'b0;
        exp_cnt = 1;
        push(K_FLAG, tick_edges + DEB, exp_cnt);
        wait_ticks(6);
        drain("pre_rst_drain");
        check("pre_rst_state", kif.key_state, 1);
        sys_rst_n = 1'b0;
        #1;
        check("midrst_state", kif.key_state, 0);
        check("midrst_cnt", kif.press_cnt, 0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        exp_cnt = 1;
        push(K_FLAG, tick_edges + DEB, exp_cnt);
        wait_ticks(6);
        kif.key_in = 1'b1;
        push(K_REL, tick_edges + DEB, 0);
        wait_ticks(6);
        drain("rst_redebounce_drain");
        check("final_cnt", kif.press_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
